operand_stream_receiver: RTL and testbench

OPERAND_STREAM_RECEIVER -- requirements
Module: operand_stream_receiver

---
 rtl/operand_stream_receiver.sv | 116 +++++++++++
 tb/tb_operand_stream_receiver.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/operand_stream_receiver.sv
// rtl/operand_stream_receiver.sv - loads a MAX_DIM x MAX_DIM operand matrix row by row and feeds it out skewed per lane
module operand_stream_receiver #(
   parameter int DATA_WIDTH = 32,
   parameter int BUS_WIDTH  = 64
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            start_i,
   input  logic                            clear_i,
   input  logic [BUS_WIDTH-1:0]            row_i,
   output logic                            start_send_o,
   output logic [BUS_WIDTH-1:0]            lane_data_o,
   output logic [BUS_WIDTH/DATA_WIDTH-1:0] lane_valid_o,
   output logic                            busy_o,
   output logic                            done_o
);

   localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
   // Wide enough to hold 2*MAX_DIM-1, the largest feed step, without wrapping.
   localparam int CNT_W   = $clog2(2 * MAX_DIM);

   localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(MAX_DIM - 1);
   localparam logic [CNT_W-1:0] LAST_T   = CNT_W'(2 * MAX_DIM - 2);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] FEED = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]           state;
   logic [CNT_W-1:0]     row_cnt;
   logic [CNT_W-1:0]     feed_cnt;
   logic [BUS_WIDTH-1:0] row_buf [MAX_DIM];
   int                   feed_t;

   assign feed_t       = int'(feed_cnt);
   assign start_send_o = (state == LOAD);
   assign busy_o       = (state != IDLE);
   assign done_o       = (state == DONE);

   // Sequencing: IDLE -> LOAD (capture rows) -> FEED (skewed output) -> DONE, with clear as a synchronous abort.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= IDLE;
         row_cnt  <= '0;
         feed_cnt <= '0;
         for (int r = 0; r < MAX_DIM; r++) begin
            row_buf[r] <= '0;
         end
      end else if (clear_i) begin
         // Buffer is deliberately kept; only control state is dropped.
         state    <= IDLE;
         row_cnt  <= '0;
         feed_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  state   <= LOAD;
                  row_cnt <= '0;
               end
            end
            LOAD: begin
               for (int r = 0; r < MAX_DIM; r++) begin
                  if (row_cnt == CNT_W'(r)) begin
                     row_buf[r] <= row_i;
                  end
               end
               if (row_cnt == LAST_ROW) begin
                  // Dropping start_send_o next cycle rewinds the store's send counter.
                  state    <= FEED;
                  row_cnt  <= '0;
                  feed_cnt <= '0;
               end else begin
                  row_cnt <= row_cnt + 1'b1;
               end
            end
            FEED: begin
               if (feed_cnt == LAST_T) begin
                  state    <= DONE;
                  feed_cnt <= '0;
               end else begin
                  feed_cnt <= feed_cnt + 1'b1;
               end
            end
            DONE: begin
               // A held start chains straight into the next load so matrices stream back to back.
               if (start_i) begin
                  state   <= LOAD;
                  row_cnt <= '0;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Skewed feed: lane i carries element t-i of row i; matching t == i+j over constant j avoids any negative index.
   always_comb begin
      lane_data_o  = '0;
      lane_valid_o = '0;
      if (state == FEED) begin
         for (int i = 0; i < MAX_DIM; i++) begin
            for (int j = 0; j < MAX_DIM; j++) begin
               if (feed_t == i + j) begin
                  lane_valid_o[i]                         = 1'b1;
                  lane_data_o[i*DATA_WIDTH +: DATA_WIDTH] = row_buf[i][j*DATA_WIDTH +: DATA_WIDTH];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_operand_stream_receiver.sv
// tb/tb_operand_stream_receiver.sv - self-checking bench for operand_stream_receiver
module tb_operand_stream_receiver;

   typedef struct packed {
      logic [63:0] r0;
      logic [63:0] r1;
      logic [63:0] d0;
      logic [1:0]  v0;
      logic [63:0] d1;
      logic [1:0]  v1;
      logic [63:0] d2;
      logic [1:0]  v2;
   } vec_t;

   typedef struct packed {
      logic [63:0] d;
      logic [1:0]  v;
   } exp_t;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        start_i;
   logic        clear_i;
   logic [63:0] row_i;
   logic        start_send_o;
   logic [63:0] lane_data_o;
   logic [1:0]  lane_valid_o;
   logic        busy_o;
   logic        done_o;

   logic [63:0] cur_r0, cur_r1;
   logic [1:0]  send_cnt;
   int          n_vec = 0;
   int          n_err = 0;
   int          done_cnt = 0;
   exp_t        sb_q[$];
   vec_t        tbl[4];

   operand_stream_receiver dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .start_i      (start_i),
      .clear_i      (clear_i),
      .row_i        (row_i),
      .start_send_o (start_send_o),
      .lane_data_o  (lane_data_o),
      .lane_valid_o (lane_valid_o),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   always #5 clk_i = ~clk_i;

   // Operand store model: presents row 0, 1, ... while start_send is high, rewinds when it drops.
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) send_cnt <= 2'd0;
      else         send_cnt <= start_send_o ? send_cnt + 2'd1 : 2'd0;
   end
   always_comb row_i = (send_cnt == 2'd0) ? cur_r0 : cur_r1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Scoreboard: every valid feed cycle pops one expected record.
   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (done_o) done_cnt++;
         if (lane_valid_o != 2'b00) begin
            n_vec++;
            if (sb_q.size() == 0) begin
               n_err++;
               $display("FAIL lane_unexpected: got data %h valid %b, required no feed", lane_data_o, lane_valid_o);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               if (lane_data_o !== e.d || lane_valid_o !== e.v) begin
                  n_err++;
                  $display("FAIL lane_feed: got data %h valid %b, required data %h valid %b",
                           lane_data_o, lane_valid_o, e.d, e.v);
               end
            end
         end else begin
            n_vec++;
            if (lane_data_o !== 64'd0) begin
               n_err++;
               $display("FAIL lane_idle_zero: got %h, required 0", lane_data_o);
            end
         end
      end
   end

   // mode 0: plain pulse, 1: extra starts in LOAD and FEED, 2: clear in FEED t1
   task automatic run_case(input vec_t v, input int mode);
      int d_before;
      @(negedge clk_i);
      cur_r0  = v.r0;
      cur_r1  = v.r1;
      start_i = 1'b1;
      sb_q.push_back({v.d0, v.v0});
      sb_q.push_back({v.d1, v.v1});
      if (mode != 2) sb_q.push_back({v.d2, v.v2});
      d_before = done_cnt;
      for (int n = 1; n <= 7; n++) begin
         @(negedge clk_i);
         if (mode != 2 || n < 5) begin
            chk($sformatf("busy_n%0d", n), 64'(busy_o), 64'(n <= 6));
            chk($sformatf("start_send_n%0d", n), 64'(start_send_o), 64'(n <= 2));
            chk($sformatf("done_n%0d", n), 64'(done_o), 64'(n == 6));
         end else begin
            chk($sformatf("clr_busy_n%0d", n), 64'(busy_o), 64'd0);
            chk($sformatf("clr_valid_n%0d", n), 64'(lane_valid_o), 64'd0);
            chk($sformatf("clr_done_n%0d", n), 64'(done_o), 64'd0);
         end
         start_i = (mode == 1 && (n == 1 || n == 3));
         clear_i = (mode == 2 && n == 4);
      end
      start_i = 1'b0;
      clear_i = 1'b0;
      chk($sformatf("done_pulses_mode%0d", mode), 64'(done_cnt - d_before), 64'(mode == 2 ? 0 : 1));
   endtask

   initial begin
      int d_before;
      tbl[0] = '{r0: 64'h00000002_00000001, r1: 64'h00000004_00000003,
                 d0: 64'h00000000_00000001, v0: 2'b01,
                 d1: 64'h00000003_00000002, v1: 2'b11,
                 d2: 64'h00000004_00000000, v2: 2'b10};
      tbl[1] = '{r0: 64'hDEADBEEF_12345678, r1: 64'hCAFEF00D_8BADF00D,
                 d0: 64'h00000000_12345678, v0: 2'b01,
                 d1: 64'h8BADF00D_DEADBEEF, v1: 2'b11,
                 d2: 64'hCAFEF00D_00000000, v2: 2'b10};
      tbl[2] = '{r0: 64'hFFFFFFFF_00000000, r1: 64'h00000000_FFFFFFFF,
                 d0: 64'h00000000_00000000, v0: 2'b01,
                 d1: 64'hFFFFFFFF_FFFFFFFF, v1: 2'b11,
                 d2: 64'h00000000_00000000, v2: 2'b10};
      tbl[3] = '{r0: 64'hAAAA0000_BBBB0000, r1: 64'hCCCC0000_DDDD0000,
                 d0: 64'h00000000_BBBB0000, v0: 2'b01,
                 d1: 64'hDDDD0000_AAAA0000, v1: 2'b11,
                 d2: 64'hCCCC0000_00000000, v2: 2'b10};

      rst_ni  = 1'b0;
      start_i = 1'b0;
      clear_i = 1'b0;
      cur_r0  = 64'd0;
      cur_r1  = 64'd0;
      repeat (2) @(negedge clk_i);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_start_send", 64'(start_send_o), 64'd0);
      chk("rst_lane_data", lane_data_o, 64'd0);
      chk("rst_lane_valid", 64'(lane_valid_o), 64'd0);
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk("idle_busy", 64'(busy_o), 64'd0);

      for (int i = 0; i < 3; i++) run_case(tbl[i], 0);
      run_case(tbl[1], 1);
      run_case(tbl[2], 2);
      run_case(tbl[0], 0);

      // Reset in the second LOAD cycle, then a full run with fresh rows.
      @(negedge clk_i);
      cur_r0  = tbl[1].r0;
      cur_r1  = tbl[1].r1;
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      @(negedge clk_i);
      chk("load2_start_send", 64'(start_send_o), 64'd1);
      #2 rst_ni = 1'b0;
      #1;
      chk("midrst_busy", 64'(busy_o), 64'd0);
      chk("midrst_start_send", 64'(start_send_o), 64'd0);
      chk("midrst_done", 64'(done_o), 64'd0);
      chk("midrst_lane_data", lane_data_o, 64'd0);
      chk("midrst_lane_valid", 64'(lane_valid_o), 64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (3) @(negedge clk_i);
      chk("postrst_idle", 64'(busy_o), 64'd0);
      run_case(tbl[3], 0);

      // Start held high: back-to-back loads, done every six cycles.
      @(negedge clk_i);
      cur_r0  = tbl[0].r0;
      cur_r1  = tbl[0].r1;
      start_i = 1'b1;
      for (int k = 0; k < 2; k++) begin
         sb_q.push_back({tbl[0].d0, tbl[0].v0});
         sb_q.push_back({tbl[0].d1, tbl[0].v1});
         sb_q.push_back({tbl[0].d2, tbl[0].v2});
      end
      d_before = done_cnt;
      for (int n = 1; n <= 13; n++) begin
         @(negedge clk_i);
         chk($sformatf("hold_busy_n%0d", n), 64'(busy_o), 64'(n <= 12));
         chk($sformatf("hold_done_n%0d", n), 64'(done_o), 64'(n == 6 || n == 12));
         chk($sformatf("hold_send_n%0d", n), 64'(start_send_o), 64'(n == 1 || n == 2 || n == 7 || n == 8));
         if (n == 12) start_i = 1'b0;
      end
      chk("hold_done_pulses", 64'(done_cnt - d_before), 64'd2);

      repeat (2) @(negedge clk_i);
      chk("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
